priority_arbiter_rr: RTL

// Registered round-robin arbiter feeding one-hot grants to a downstream consumer.
// - Samples a request vector and picks one requester by rightmost-priority search.
// - The search starts just above the most recently accepted grant.
// - Presents the grant as one-hot plus binary index over a valid/ready handshake.
// - Holds the grant stable until the consumer accepts it.
//

---
 rtl/priority_arbiter_rr.sv | 101 ++++++++++
 1 files changed

// File: rtl/priority_arbiter_rr.sv
// Registered round-robin arbiter: one-hot + index grant over valid/ready,
// search begins just above the most recently accepted grant.
//
// state | meaning
// IDLE  | no grant presented (gnt_vld=0)
// GRANT | grant presented, held until gnt_rdy
module priority_arbiter_rr #(
    parameter int WIDTH     = 32,
    localparam int WIDTH_LOG = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     req,
    output logic [WIDTH-1:0]     gnt_oht,
    output logic [WIDTH_LOG-1:0] gnt_idx,
    output logic                 gnt_vld,
    input  logic                 gnt_rdy
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [WIDTH-1:0]     gnt_oht_q, gnt_oht_d;
    logic [WIDTH_LOG-1:0] gnt_idx_q, gnt_idx_d;
    logic [WIDTH_LOG-1:0] last_q, last_d;

    logic [WIDTH_LOG-1:0] base;
    logic [WIDTH_LOG-1:0] hi_idx, lo_idx, pick_idx;
    logic                 hi_found, lo_found;
    logic [WIDTH-1:0]     pick_oht;

    // On acceptance the mask is built from the grant being retired, so a
    // back-to-back grant skips past it without waiting for last_q to update.
    always_comb begin
        base     = (state_q == GRANT && gnt_rdy) ? gnt_idx_q : last_q;
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_found = 1'b1;
                lo_idx   = WIDTH_LOG'(i);
                if (i > int'(base)) begin
                    hi_found = 1'b1;
                    hi_idx   = WIDTH_LOG'(i);
                end
            end
        end
        pick_idx = hi_found ? hi_idx : lo_idx;
        pick_oht = WIDTH'(1) << pick_idx;
    end

    always_comb begin
        state_d   = state_q;
        gnt_oht_d = gnt_oht_q;
        gnt_idx_d = gnt_idx_q;
        last_d    = last_q;
        case (state_q)
            IDLE: begin
                if (lo_found) begin
                    state_d   = GRANT;
                    gnt_oht_d = pick_oht;
                    gnt_idx_d = pick_idx;
                end
            end
            GRANT: begin
                if (gnt_rdy) begin
                    last_d = gnt_idx_q;
                    if (lo_found) begin
                        gnt_oht_d = pick_oht;
                        gnt_idx_d = pick_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_oht_q <= '0;
            gnt_idx_q <= '0;
            last_q    <= WIDTH_LOG'(WIDTH - 1);
        end else begin
            state_q   <= state_d;
            gnt_oht_q <= gnt_oht_d;
            gnt_idx_q <= gnt_idx_d;
            last_q    <= last_d;
        end
    end

    assign gnt_oht = gnt_oht_q;
    assign gnt_idx = gnt_idx_q;
    assign gnt_vld = (state_q == GRANT);

endmodule
